reg_access_ctrl: RTL and testbench

//   Command sequencer directly upstream of the 2-bit register block (CLK/RST/WRITE/READ/ADDR/

---
 rtl/reg_access_pkg.sv | 15 +
 rtl/reg_access_ctrl_if.sv | 27 ++
 rtl/reg_access_ctrl.sv | 148 ++++++++++++++
 tb/tb_reg_access_ctrl.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/reg_access_pkg.sv
// rtl/reg_access_pkg.sv - shared state encoding and bus width defaults for the register access path
package reg_access_pkg;

  localparam int REG_ADDR_W = 3;
  localparam int REG_DATA_W = 2;
  localparam int RD_CNT_W   = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// rtl/reg_access_ctrl_if.sv - host command/response valid-ready channel of the register access sequencer
interface reg_access_ctrl_if #(
  parameter int ADDR_W = reg_access_pkg::REG_ADDR_W,
  parameter int DATA_W = reg_access_pkg::REG_DATA_W
);

  logic              CMD_VALID;
  logic              CMD_READY;
  logic              CMD_WRITE;
  logic [ADDR_W-1:0] CMD_ADDR;
  logic [DATA_W-1:0] CMD_WDATA;
  logic              RSP_VALID;
  logic              RSP_READY;
  logic [DATA_W-1:0] RSP_RDATA;
  logic              RSP_ERR;

  modport master (
    output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
    input  CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

  modport slave (
    input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_WDATA, RSP_READY,
    output CMD_READY, RSP_VALID, RSP_RDATA, RSP_ERR
  );

endinterface

// File: rtl/reg_access_ctrl.sv
// rtl/reg_access_ctrl.sv - single-outstanding command sequencer driving the 2-bit register block
// Optional unmapped-address rejection is enabled by defining REG_ACCESS_ADDR_CHECK_EN.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int ADDR_W   = REG_ADDR_W,
  parameter int DATA_W   = REG_DATA_W,
  parameter int RD_LAT   = 1,
  parameter int NUM_REGS = 1
) (
  input  logic              CLK,
  input  logic              RST_N,
  reg_access_ctrl_if.slave  host,
  output logic              WRITE,
  output logic              READ,
  output logic [ADDR_W-1:0] ADDR,
  output logic [DATA_W-1:0] WRITE_DATA,
  input  logic [DATA_W-1:0] READ_DATA
);

  state_t              state_q,     state_d;
  logic [RD_CNT_W-1:0] cnt_q,       cnt_d;
  logic                is_wr_q,     is_wr_d;
  logic                cmd_ready_q, cmd_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;
  logic                write_q,     write_d;
  logic                read_q,      read_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic [DATA_W-1:0]   wdata_q,     wdata_d;
  logic                addr_err;

  always_comb begin
`ifdef REG_ACCESS_ADDR_CHECK_EN
    addr_err = (int'(host.CMD_ADDR) >= NUM_REGS);
`else
    addr_err = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    is_wr_d     = is_wr_q;
    cmd_ready_d = cmd_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    write_d     = 1'b0;
    read_d      = 1'b0;

    case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (host.CMD_VALID && cmd_ready_q) begin
          addr_d      = host.CMD_ADDR;
          wdata_d     = host.CMD_WDATA;
          is_wr_d     = host.CMD_WRITE;
          cmd_ready_d = 1'b0;
          rsp_err_d   = addr_err;
          if (addr_err) begin
            // Rejected commands skip the register block entirely.
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
          end else begin
            state_d = ISSUE;
            write_d = host.CMD_WRITE;
            read_d  = !host.CMD_WRITE;
          end
        end
      end
      ISSUE: begin
        if (is_wr_q) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = '0;
        end else if (RD_LAT == 0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = READ_DATA;
        end else begin
          state_d = WAIT;
          cnt_d   = RD_CNT_W'(RD_LAT - 1);
        end
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_rdata_d = READ_DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (host.RSP_READY) begin
          // Raising ready here lets the next command land in the first IDLE cycle.
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      is_wr_q     <= 1'b0;
      cmd_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      write_q     <= 1'b0;
      read_q      <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      is_wr_q     <= is_wr_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      write_q     <= write_d;
      read_q      <= read_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  assign host.CMD_READY = cmd_ready_q;
  assign host.RSP_VALID = rsp_valid_q;
  assign host.RSP_RDATA = rsp_rdata_q;
  assign host.RSP_ERR   = rsp_err_q;
  assign WRITE          = write_q;
  assign READ           = read_q;
  assign ADDR           = addr_q;
  assign WRITE_DATA     = wdata_q;

endmodule

// File: tb/tb_reg_access_ctrl.sv
// tb/tb_reg_access_ctrl.sv - randomized and directed self-checking bench for reg_access_ctrl
module tb_reg_access_ctrl;

  localparam int ADDR_W   = 3;
  localparam int DATA_W   = 2;
  localparam int RD_LAT   = 1;
  localparam int NUM_REGS = 1;

  logic              CLK = 1'b0;
  logic              RST_N = 1'b0;
  logic              WRITE, READ;
  logic [ADDR_W-1:0] ADDR;
  logic [DATA_W-1:0] WRITE_DATA;
  logic [DATA_W-1:0] READ_DATA = '0;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  reg_access_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) host_if ();

  reg_access_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .RD_LAT(RD_LAT), .NUM_REGS(NUM_REGS)
  ) dut (
    .CLK(CLK), .RST_N(RST_N), .host(host_if),
    .WRITE(WRITE), .READ(READ), .ADDR(ADDR),
    .WRITE_DATA(WRITE_DATA), .READ_DATA(READ_DATA)
  );

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  // Emulated register block: data appears one cycle after the READ strobe.
  logic [DATA_W-1:0] blk_mem [8];
  always @(posedge CLK) begin
    if (WRITE) blk_mem[ADDR] <= WRITE_DATA;
    if (READ)  READ_DATA <= blk_mem[ADDR];
  end

  function automatic void chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Transaction-schedule model: what each cycle must show, derived from accept time and latency.
  logic [DATA_W-1:0] mdl_mem [8];
  bit                busy = 0;
  int                ready_from = 2;
  int                t_acc, t_rsp;
  bit                t_wr, t_err;
  logic [ADDR_W-1:0] t_addr, last_addr = '0;
  logic [DATA_W-1:0] t_wdata, t_rdata, last_wdata = '0;

  initial begin
    for (int i = 0; i < 8; i++) begin
      blk_mem[i] = '0;
      mdl_mem[i] = '0;
    end
  end

  always @(negedge CLK) begin
    bit exp_ready, exp_wr, exp_rd, exp_valid;
    if (!RST_N) begin
      chk("rst_cmd_ready", host_if.CMD_READY, 0);
      chk("rst_rsp_valid", host_if.RSP_VALID, 0);
      chk("rst_rsp_rdata", host_if.RSP_RDATA, 0);
      chk("rst_rsp_err", host_if.RSP_ERR, 0);
      chk("rst_write", WRITE, 0);
      chk("rst_read", READ, 0);
      chk("rst_addr", ADDR, 0);
      chk("rst_wdata", WRITE_DATA, 0);
      busy = 0;
      last_addr = '0;
      last_wdata = '0;
      ready_from = cyc + 2;
    end else begin
      if (busy && cyc >= t_acc) begin
        last_addr  = t_addr;
        last_wdata = t_wdata;
      end
      exp_ready = !busy && cyc >= ready_from;
      exp_wr    = busy && cyc == t_acc && t_wr && !t_err;
      exp_rd    = busy && cyc == t_acc && !t_wr && !t_err;
      exp_valid = busy && cyc >= t_rsp;
      chk("cmd_ready", host_if.CMD_READY, int'(exp_ready));
      chk("write_strobe", WRITE, int'(exp_wr));
      chk("read_strobe", READ, int'(exp_rd));
      chk("rsp_valid", host_if.RSP_VALID, int'(exp_valid));
      chk("addr", ADDR, last_addr);
      chk("write_data", WRITE_DATA, last_wdata);
      if (exp_valid) begin
        chk("rsp_rdata", host_if.RSP_RDATA, t_rdata);
        chk("rsp_err", host_if.RSP_ERR, int'(t_err));
      end
      if (exp_valid && host_if.RSP_READY) begin
        busy = 0;
        ready_from = cyc + 1;
      end else if (exp_ready && host_if.CMD_VALID) begin
        busy    = 1;
        t_acc   = cyc + 1;
        t_wr    = host_if.CMD_WRITE;
        t_addr  = host_if.CMD_ADDR;
        t_wdata = host_if.CMD_WDATA;
`ifdef REG_ACCESS_ADDR_CHECK_EN
        t_err   = int'(t_addr) >= NUM_REGS;
`else
        t_err   = 0;
`endif
        t_rsp   = t_err ? t_acc : (t_wr ? t_acc + 1 : t_acc + 1 + RD_LAT);
        t_rdata = (t_err || t_wr) ? '0 : mdl_mem[t_addr];
        if (t_wr && !t_err) mdl_mem[t_addr] = t_wdata;
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issues one command, returns edges from accept (inclusive) to RSP_VALID and the response.
  task automatic do_cmd(input bit wr, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                        input int hold, output int edges, output logic [DATA_W-1:0] rd,
                        output logic er);
    int k = 0;
    host_if.CMD_VALID = 1'b1;
    host_if.CMD_WRITE = wr;
    host_if.CMD_ADDR  = a;
    host_if.CMD_WDATA = d;
    host_if.RSP_READY = 1'b0;
    while (!host_if.CMD_READY && k < 20) begin
      step();
      k++;
    end
    chk("accept_timeout", int'(k < 20), 1);
    step();
    host_if.CMD_VALID = 1'b0;
    edges = 1;
    while (!host_if.RSP_VALID && edges < 20) begin
      step();
      edges++;
    end
    chk("rsp_timeout", int'(edges < 20), 1);
    rd = host_if.RSP_RDATA;
    er = host_if.RSP_ERR;
    if (hold > 0) begin
      host_if.CMD_VALID = 1'b1;
      host_if.CMD_WRITE = 1'b1;
      host_if.CMD_ADDR  = 3'd3;
      host_if.CMD_WDATA = 2'd1;
      repeat (hold) step();
      host_if.CMD_VALID = 1'b0;
      chk("hold_rsp_valid", host_if.RSP_VALID, 1);
      chk("hold_rsp_rdata", host_if.RSP_RDATA, rd);
      chk("hold_cmd_ready", host_if.CMD_READY, 0);
    end
    host_if.RSP_READY = 1'b1;
    step();
    host_if.RSP_READY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors %0d", errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int e;
    logic [DATA_W-1:0] rd;
    logic er;
    int k;
    host_if.CMD_VALID = 1'b0;
    host_if.CMD_WRITE = 1'b0;
    host_if.CMD_ADDR  = '0;
    host_if.CMD_WDATA = '0;
    host_if.RSP_READY = 1'b0;

    repeat (3) step();
    chk("por_cmd_ready", host_if.CMD_READY, 0);
    chk("por_write", WRITE, 0);
    RST_N = 1'b1;
    chk("release_ready_before_edge", host_if.CMD_READY, 0);
    step();
    chk("release_ready_after_edge", host_if.CMD_READY, 1);

    do_cmd(1'b1, 3'd0, 2'b10, 0, e, rd, er);
    chk("write_latency_edges", e, 2);
    chk("write_rsp_rdata", rd, 0);

    do_cmd(1'b0, 3'd0, 2'b00, 0, e, rd, er);
    chk("read_latency_edges", e, 3);
    chk("read_rsp_rdata", rd, 2);

    do_cmd(1'b0, 3'd0, 2'b00, 5, e, rd, er);
    chk("stall_read_rdata", rd, 2);

    // Reset while the read is waiting on the register block.
    host_if.CMD_VALID = 1'b1;
    host_if.CMD_WRITE = 1'b0;
    host_if.CMD_ADDR  = 3'd0;
    k = 0;
    while (!host_if.CMD_READY && k < 20) begin
      step();
      k++;
    end
    step();
    host_if.CMD_VALID = 1'b0;
    chk("issue_read_strobe", READ, 1);
    step();
    RST_N = 1'b0;
    #1;
    chk("midrst_read", READ, 0);
    chk("midrst_rsp_valid", host_if.RSP_VALID, 0);
    chk("midrst_cmd_ready", host_if.CMD_READY, 0);
    step();
    step();
    RST_N = 1'b1;
    step();
    chk("midrst_ready_after_edge", host_if.CMD_READY, 1);

`ifdef REG_ACCESS_ADDR_CHECK_EN
    do_cmd(1'b0, 3'd5, 2'b00, 0, e, rd, er);
    chk("unmapped_latency_edges", e, 1);
    chk("unmapped_err", er, 1);
    chk("unmapped_rdata", rd, 0);
`endif

    for (int i = 0; i < 1500; i++) begin
      host_if.CMD_VALID = 1'($urandom_range(0, 1));
      host_if.CMD_WRITE = 1'($urandom_range(0, 1));
      host_if.CMD_ADDR  = ADDR_W'($urandom_range(0, 7));
      host_if.CMD_WDATA = DATA_W'($urandom_range(0, 3));
      host_if.RSP_READY = ($urandom_range(0, 3) != 0);
      step();
    end
    host_if.CMD_VALID = 1'b0;
    host_if.RSP_READY = 1'b1;
    repeat (6) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
